// File: rtl/cv32e40s_tb_obi_stall_bridge.sv
// OBI bridge between a cv32e40s OBI port and mm_ram. It inserts LFSR-driven grant and response
// delays. Optional parity error injection: define CV32E40S_TB_OBI_PARITY_ERR_INJ_EN.
module cv32e40s_tb_obi_stall_bridge #(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned MAX_OUTSTANDING  = 2,
    parameter int unsigned GNT_DELAY_MAX    = 3,
    parameter int unsigned RVALID_DELAY_MAX = 3,
    parameter logic [31:0] LFSR_SEED        = 32'hACE1_0001
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_en_i,
`ifdef CV32E40S_TB_OBI_PARITY_ERR_INJ_EN
    input  logic                  inject_par_err_i,
`endif
    input  logic                  req_i,
    input  logic [31:0]           addr_i,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  gnt_o,
    output logic                  gntpar_o,
    output logic                  rvalid_o,
    output logic                  rvalidpar_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  mem_req_o,
    output logic [31:0]           mem_addr_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [2:0]            outstanding_o,
    output logic                  protocol_err_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ARB  = 2'd2;

    logic [31:0]           lfsr_q, lfsr_d;
    logic [3:0]            gnt_delay, rsp_delay;
    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  arb, room, gnt;
    logic [2:0]            outstanding_q, mem_pend_q;
    logic [2:0]            fifo_cnt_q;
    logic [1:0]            rd_ptr_q, wr_ptr_q;
    logic [DATA_WIDTH-1:0] fifo_q [4];
    logic                  head_armed_q;
    logic [3:0]            rcnt_q, cur_delay;
    logic                  push, head_valid, fire, store, pop;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  rvalid_q, perr_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    assign lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 32'h8000_0057) : (lfsr_q >> 1);

    assign gnt_delay = stall_en_i ? 4'(32'(lfsr_q[3:0]) % (GNT_DELAY_MAX + 1)) : 4'd0;
    assign rsp_delay = stall_en_i ? 4'(32'(lfsr_q[7:4]) % (RVALID_DELAY_MAX + 1)) : 4'd0;

    // A zero grant delay falls through from IDLE to arbitration in the same cycle.
    assign arb       = (state_q == ST_ARB) || ((state_q == ST_IDLE) && (gnt_delay == 4'd0));
    assign room      = outstanding_q < 3'(MAX_OUTSTANDING);
    assign mem_req_o = arb && req_i && room;
    assign gnt       = mem_req_o && mem_gnt_i;
    assign gnt_o     = gnt;

    assign mem_addr_o  = addr_i;
    assign mem_we_o    = we_i;
    assign mem_be_o    = be_i;
    assign mem_wdata_o = wdata_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    if (gnt_delay == 4'd0) begin
                        state_d = ST_ARB;
                    end else begin
                        cnt_d   = gnt_delay;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!req_i)              state_d = ST_IDLE;
                else if (cnt_q == 4'd1)  state_d = ST_ARB;
                else                     cnt_d   = cnt_q - 4'd1;
            end
            ST_ARB:  if (!req_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (gnt) state_d = ST_IDLE;
    end

    // The head is either the oldest stored entry or, with an empty FIFO, the incoming response.
    assign push       = mem_rvalid_i && (mem_pend_q != 3'd0);
    assign head_valid = (fifo_cnt_q != 3'd0) || push;
    assign head_data  = (fifo_cnt_q != 3'd0) ? fifo_q[rd_ptr_q] : mem_rdata_i;
    assign cur_delay  = head_armed_q ? rcnt_q : rsp_delay;
    assign fire       = head_valid && (cur_delay == 4'd0);
    assign pop        = fire && (fifo_cnt_q != 3'd0);
    assign store      = push && !(fire && (fifo_cnt_q == 3'd0));

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (32'(p) == MAX_OUTSTANDING - 1) ? 2'd0 : p + 2'd1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (store) fifo_q[wr_ptr_q] <= mem_rdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q        <= LFSR_SEED;
            state_q       <= ST_IDLE;
            cnt_q         <= 4'd0;
            outstanding_q <= 3'd0;
            mem_pend_q    <= 3'd0;
            fifo_cnt_q    <= 3'd0;
            rd_ptr_q      <= 2'd0;
            wr_ptr_q      <= 2'd0;
            head_armed_q  <= 1'b0;
            rcnt_q        <= 4'd0;
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
            perr_q        <= 1'b0;
        end else begin
            lfsr_q        <= lfsr_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            outstanding_q <= outstanding_q + 3'(gnt) - 3'(rvalid_q);
            mem_pend_q    <= mem_pend_q + 3'(gnt) - 3'(push);
            fifo_cnt_q    <= fifo_cnt_q + 3'(store) - 3'(pop);
            if (store) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)   rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (fire) begin
                head_armed_q <= 1'b0;
                rdata_q      <= head_data;
            end else if (head_valid) begin
                head_armed_q <= 1'b1;
                rcnt_q       <= cur_delay - 4'd1;
            end
            rvalid_q <= fire;
            if (mem_rvalid_i && (mem_pend_q == 3'd0)) perr_q <= 1'b1;
        end
    end

    assign rvalid_o       = rvalid_q;
    assign rdata_o        = rdata_q;
    assign outstanding_o  = outstanding_q;
    assign protocol_err_o = perr_q;

`ifdef CV32E40S_TB_OBI_PARITY_ERR_INJ_EN
    logic inj_q, gnt_arm_q, rv_arm_q, inj_rise;

    assign inj_rise = inject_par_err_i && !inj_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inj_q     <= 1'b0;
            gnt_arm_q <= 1'b0;
            rv_arm_q  <= 1'b0;
        end else begin
            inj_q     <= inject_par_err_i;
            gnt_arm_q <= (gnt_arm_q && !gnt) || inj_rise;
            rv_arm_q  <= (rv_arm_q && !rvalid_q) || inj_rise;
        end
    end

    assign gntpar_o    = !gnt || gnt_arm_q;
    assign rvalidpar_o = !rvalid_q || rv_arm_q;
`else
    assign gntpar_o    = !gnt;
    assign rvalidpar_o = !rvalid_q;
`endif

endmodule

// File: tb/tb_cv32e40s_tb_obi_stall_bridge.sv
// Directed and randomized bench for cv32e40s_tb_obi_stall_bridge with a cycle-level timing model.
module tb_cv32e40s_tb_obi_stall_bridge;

    localparam logic [31:0] SEED = 32'h0000_0001;

    logic        clk = 1'b0;
    logic        rst, stall_en, req, we, gnt, gntpar, rvalid, rvalidpar;
    logic [31:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  be, mem_be;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid, perr;
    logic [2:0]  outstanding;
`ifdef CV32E40S_TB_OBI_PARITY_ERR_INJ_EN
    logic        inj = 1'b0;
`endif

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [31:0] m_lfsr = SEED;

    always #5 clk = ~clk;

    cv32e40s_tb_obi_stall_bridge #(
        .DATA_WIDTH(32), .MAX_OUTSTANDING(2), .GNT_DELAY_MAX(3), .RVALID_DELAY_MAX(3),
        .LFSR_SEED(SEED)
    ) dut (
        .clk_i(clk), .rst_i(rst), .stall_en_i(stall_en),
`ifdef CV32E40S_TB_OBI_PARITY_ERR_INJ_EN
        .inject_par_err_i(inj),
`endif
        .req_i(req), .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata),
        .gnt_o(gnt), .gntpar_o(gntpar), .rvalid_o(rvalid), .rvalidpar_o(rvalidpar),
        .rdata_o(rdata), .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_we_o(mem_we),
        .mem_be_o(mem_be), .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .outstanding_o(outstanding),
        .protocol_err_o(perr)
    );

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ 32'h8000_0057) : (x >> 1);
    endfunction

    // Advance one clock; the model LFSR follows the reset the DUT sampled on this edge.
    task automatic tick();
        @(posedge clk);
        m_lfsr = rst ? SEED : lfsr_step(m_lfsr);
        cyc++;
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int          x, g_exp, g_at, lat, a, r_exp, r_at;
    logic [3:0]  dg, dr;
    logic [31:0] data, r_data;

    initial begin
        rst = 1'b1; stall_en = 1'b0; req = 1'b0; we = 1'b0; addr = '0; be = 4'hf;
        wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        tick(); tick();
        @(negedge clk);
        check("rst_gnt", 32'(gnt), 0);
        check("rst_rvalid", 32'(rvalid), 0);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_rdata", rdata, 0);
        check("rst_outstanding", 32'(outstanding), 0);
        check("rst_perr", 32'(perr), 0);
        check("rst_gntpar", 32'(gntpar), 1);
        check("rst_rvalidpar", 32'(rvalidpar), 1);

        // Single zero-delay read
        tick(); rst = 1'b0;
        req = 1'b1; addr = 32'h80; mem_gnt = 1'b1;
        @(negedge clk);
        check("rd_gnt", 32'(gnt), 1);
        check("rd_gntpar", 32'(gntpar), 0);
        check("rd_mem_req", 32'(mem_req), 1);
        check("rd_mem_addr", mem_addr, 32'h80);
        tick(); req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h13;
        @(negedge clk);
        check("rd_rvalid_early", 32'(rvalid), 0);
        check("rd_outstanding", 32'(outstanding), 1);
        tick(); mem_rvalid = 1'b0;
        @(negedge clk);
        check("rd_rvalid", 32'(rvalid), 1);
        check("rd_rdata", rdata, 32'h13);
        check("rd_rvalidpar", 32'(rvalidpar), 0);
        tick();
        @(negedge clk);
        check("rd_outstanding_end", 32'(outstanding), 0);

        // Back-to-back requests against the outstanding limit
        tick(); req = 1'b1; addr = 32'h100;
        @(negedge clk);
        check("b2b_gnt0", 32'(gnt), 1);
        tick(); addr = 32'h104;
        @(negedge clk);
        check("b2b_gnt1", 32'(gnt), 1);
        tick(); addr = 32'h108;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("b2b_blocked", 32'(gnt), 0);
            check("b2b_out2", 32'(outstanding), 2);
            tick();
        end
        mem_rvalid = 1'b1; mem_rdata = 32'hA0;
        @(negedge clk);
        check("b2b_blocked_rsp", 32'(gnt), 0);
        tick(); mem_rvalid = 1'b0;
        @(negedge clk);
        check("b2b_rvalid_a", 32'(rvalid), 1);
        check("b2b_rdata_a", rdata, 32'hA0);
        check("b2b_blocked_on_rvalid", 32'(gnt), 0);
        check("b2b_out_on_rvalid", 32'(outstanding), 2);
        tick();
        @(negedge clk);
        check("b2b_gnt2", 32'(gnt), 1);
        check("b2b_out1", 32'(outstanding), 1);
        tick(); req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hB0;
        @(negedge clk);
        tick(); mem_rdata = 32'hC0;
        @(negedge clk);
        check("b2b_rdata_b", rdata, 32'hB0);
        tick(); mem_rvalid = 1'b0;
        @(negedge clk);
        check("b2b_rvalid_c", 32'(rvalid), 1);
        check("b2b_rdata_c", rdata, 32'hC0);
        tick();
        @(negedge clk);
        check("b2b_out_end", 32'(outstanding), 0);

        // Reset one cycle after a grant, with the response arriving in the reset cycle
        tick(); req = 1'b1;
        @(negedge clk);
        check("rstmid_gnt", 32'(gnt), 1);
        tick(); req = 1'b0; rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD;
        @(negedge clk);
        tick(); rst = 1'b0; mem_rvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rstmid_rvalid", 32'(rvalid), 0);
            check("rstmid_out", 32'(outstanding), 0);
            check("rstmid_gntpar", 32'(gntpar), 1);
            tick();
        end

        // Unsolicited response
        mem_rvalid = 1'b1; mem_rdata = 32'h55;
        @(negedge clk);
        tick(); mem_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("perr_set", 32'(perr), 1);
            check("perr_no_rvalid", 32'(rvalid), 0);
            tick();
        end
        rst = 1'b1;
        tick(); rst = 1'b0;
        @(negedge clk);
        check("perr_cleared", 32'(perr), 0);

        // Randomized serialized reads with stalls enabled
        stall_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(); mem_rvalid = 1'b0;
            req = 1'b1; addr = $urandom; we = 1'b0;
            x = cyc; dg = 4'(m_lfsr[3:0] % 4);
            g_exp = (dg == 4'd0) ? x : x + int'(dg) + 1;
            g_at = -1;
            for (int k = 0; k < 12 && g_at < 0; k++) begin
                if (k > 0) tick();
                @(negedge clk);
                if (gnt) g_at = cyc;
            end
            check("rnd_gnt_cycle", g_at, g_exp);
            tick(); req = 1'b0;
            lat = $urandom_range(1, 3);
            data = $urandom;
            for (int j = 1; j < lat; j++) tick();
            mem_rvalid = 1'b1; mem_rdata = data;
            a = cyc; dr = 4'(m_lfsr[7:4] % 4);
            r_exp = a + int'(dr) + 1;
            r_at = -1; r_data = '0;
            for (int k = 0; k < 12 && r_at < 0; k++) begin
                if (k > 0) begin
                    tick(); mem_rvalid = 1'b0;
                end
                @(negedge clk);
                if (rvalid) begin
                    r_at = cyc; r_data = rdata;
                end
            end
            check("rnd_rvalid_cycle", r_at, r_exp);
            check("rnd_rdata", r_data, data);
        end
        tick(); mem_rvalid = 1'b0; stall_en = 1'b0;

`ifdef CV32E40S_TB_OBI_PARITY_ERR_INJ_EN
        inj = 1'b1;
        tick(); inj = 1'b0;
        tick(); req = 1'b1; we = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        check("inj_gnt", 32'(gnt), 1);
        check("inj_gntpar", 32'(gntpar), 1);
        tick(); req = 1'b0; mem_rvalid = 1'b1;
        tick(); mem_rvalid = 1'b0;
        @(negedge clk);
        check("inj_rvalid", 32'(rvalid), 1);
        check("inj_rvalidpar", 32'(rvalidpar), 1);
        tick(); req = 1'b1;
        @(negedge clk);
        check("inj_next_gntpar", 32'(gntpar), 0);
        tick(); req = 1'b0; mem_rvalid = 1'b1;
        tick(); mem_rvalid = 1'b0;
        @(negedge clk);
        check("inj_next_rvalid", 32'(rvalid), 1);
        check("inj_next_rvalidpar", 32'(rvalidpar), 0);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
